// File: rtl/ervp_apb_initiator_if.sv
`default_nettype none
// ============================================================================
//  Module      : ervp_apb_initiator_if
//  Description : Request/response stream and APB bus bundle for the
//                single-outstanding APB initiator.
//  Revision    : 1.0  initial release
// ============================================================================
interface ervp_apb_initiator_if #(
    parameter int BW_ADDR = 12,
    parameter int BW_DATA = 32
);
    // Request stream
    logic               req_valid;
    logic               req_ready;
    logic               req_write;
    logic [BW_ADDR-1:0] req_addr;
    logic [BW_DATA-1:0] req_wdata;

    // Response stream
    logic               rsp_valid;
    logic               rsp_ready;
    logic [BW_DATA-1:0] rsp_rdata;
    logic               rsp_error;
    logic               rsp_timeout;
    logic               busy;

    // APB link
    logic               apb_psel;
    logic               apb_penable;
    logic               apb_pwrite;
    logic [BW_ADDR-1:0] apb_paddr;
    logic [BW_DATA-1:0] apb_pwdata;
    logic [BW_DATA-1:0] apb_prdata;
    logic               apb_pready;
    logic               apb_pslverr;

    // Initiator view: accepts requests, issues APB transfers, returns responses
    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  rsp_ready,
        input  apb_prdata, apb_pready, apb_pslverr,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_error, rsp_timeout, busy,
        output apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata
    );

    // Environment view: request source, response sink and APB completer
    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output rsp_ready,
        output apb_prdata, apb_pready, apb_pslverr,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_error, rsp_timeout, busy,
        input  apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata
    );
endinterface
`default_nettype wire

// File: rtl/ervp_apb_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : ervp_apb_initiator
//  Description : Single-outstanding APB initiator. Turns a valid/ready
//                request stream into APB SETUP/ACCESS phases and returns a
//                valid/ready response with read data, slave error and
//                ACCESS-phase timeout status.
//  Revision    : 1.0  initial release
// ============================================================================
module ervp_apb_initiator #(
    parameter int BW_ADDR        = 12,
    parameter int BW_DATA        = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    ervp_apb_initiator_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Timeout fires when the counter reaches TIMEOUT_CYCLES-1 with pready low,
    // so ACCESS lasts exactly TIMEOUT_CYCLES cycles. Zero disables it.
    localparam bit          C_TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] C_TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t               state_q;
    state_t               state_d;
    logic [15:0]          cnt_q;
    logic                 pwrite_q;
    logic [BW_ADDR-1:0]   paddr_q;
    logic [BW_DATA-1:0]   pwdata_q;
    logic [BW_DATA-1:0]   rdata_q;
    logic                 error_q;
    logic                 timeout_q;

    logic                 w_req_fire;
    logic                 w_access_done;
    logic                 w_access_to;

    assign w_req_fire    = (state_q == ST_IDLE) && bus.req_valid;
    assign w_access_done = (state_q == ST_ACCESS) && bus.apb_pready;
    // pready has priority over a coinciding timeout
    assign w_access_to   = (state_q == ST_ACCESS) && !bus.apb_pready &&
                           C_TO_EN && (cnt_q == C_TO_LAST);

    // State register; reset forces IDLE so all decoded APB strobes drop at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (w_req_fire) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (w_access_done || w_access_to) state_d = ST_RESP;
            ST_RESP:   if (bus.rsp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // ACCESS wait counter: cleared in SETUP, counts pready-low ACCESS cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else if (state_q == ST_SETUP) begin
            cnt_q <= 16'd0;
        end else if ((state_q == ST_ACCESS) && !bus.apb_pready) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    // APB address/control/data latched on acceptance and held until the next one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
        end else if (w_req_fire) begin
            pwrite_q <= bus.req_write;
            paddr_q  <= bus.req_addr;
            pwdata_q <= bus.req_wdata;
        end
    end

    // Response capture at the end of ACCESS; held stable through RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q   <= '0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else if (w_access_done) begin
            rdata_q   <= pwrite_q ? '0 : bus.apb_prdata;
            error_q   <= bus.apb_pslverr;
            timeout_q <= 1'b0;
        end else if (w_access_to) begin
            rdata_q   <= '0;
            error_q   <= 1'b1;
            timeout_q <= 1'b1;
        end
    end

    // Handshake and APB strobes are pure state decodes
    assign bus.req_ready   = (state_q == ST_IDLE);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.apb_psel    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign bus.apb_penable = (state_q == ST_ACCESS);
    assign bus.rsp_valid   = (state_q == ST_RESP);

    assign bus.apb_pwrite  = pwrite_q;
    assign bus.apb_paddr   = paddr_q;
    assign bus.apb_pwdata  = pwdata_q;
    assign bus.rsp_rdata   = rdata_q;
    assign bus.rsp_error   = error_q;
    assign bus.rsp_timeout = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_ervp_apb_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ervp_apb_initiator
//  Description : Scoreboard bench for ervp_apb_initiator with a behavioural
//                APB completer and a transaction-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ervp_apb_initiator;

    localparam int T      = 8;      // DUT timeout under test
    localparam int STUCK  = 1000;   // wait count meaning "pready never rises"

    logic clk;
    logic rst;
    int   cyc;
    int   n_chk;
    int   n_pass;
    int   bp_left;
    bit   rand_ready;
    bit   holding;
    int   last_alen;

    ervp_apb_initiator_if #(.BW_ADDR(12), .BW_DATA(32)) bus ();

    ervp_apb_initiator #(
        .BW_ADDR        (12),
        .BW_DATA        (32),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        int          w;
        logic        err;
    } plan_t;

    typedef struct {
        logic [31:0] rdata;
        logic        error;
        logic        timeout;
        int          lat;
        int          alen;
        int          acc_cyc;
    } exp_t;

    plan_t       plan_q [$];
    exp_t        exp_q  [$];
    logic [31:0] model_mem [int];
    logic [31:0] slave_mem [int];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_val(input logic [11:0] a);
        return 32'hC0DE_0000 ^ {20'd0, a};
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] a);
        if (model_mem.exists(int'(a))) return model_mem[int'(a)];
        return init_val(a);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic bound_fail(input string name);
        n_chk++;
        $display("FAIL %s: got bound expired expected DUT event", name);
    endtask

    // Issue one request; the expected response is derived from transaction rules
    task automatic issue(input logic wr, input logic [11:0] a, input logic [31:0] d,
                         input int w, input logic err);
        plan_t p;
        exp_t  e;
        bit    to;
        int    guard;
        to        = (w >= T);
        p         = '{wr, a, d, w, err};
        e.rdata   = (to || wr) ? 32'd0 : model_read(a);
        e.error   = to | err;
        e.timeout = to;
        e.lat     = to ? T + 2 : 3 + w;
        e.alen    = to ? T : w + 1;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        guard = 0;
        while (!bus.req_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready) begin
            bound_fail("req_accept");
            bus.req_valid = 1'b0;
            return;
        end
        if (wr && !to && !err) model_mem[int'(a)] = d;
        e.acc_cyc = cyc;
        plan_q.push_back(p);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom);
        bus.req_addr  = 12'($urandom);
        bus.req_wdata = $urandom;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || bus.rsp_valid) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) bound_fail("drain");
        @(negedge clk);
    endtask

    // APB completer: follows each transfer's plan for wait states and pslverr
    initial begin : p_slave
        plan_t cur;
        bit    in_acc;
        int    acc_n;
        bit    rdy;
        in_acc = 0;
        acc_n  = 0;
        cur    = '{1'b0, 12'd0, 32'd0, 0, 1'b0};
        bus.apb_pready  = 1'b0;
        bus.apb_pslverr = 1'b0;
        bus.apb_prdata  = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst && bus.apb_psel && bus.apb_penable) begin
                if (!in_acc) begin
                    in_acc = 1;
                    acc_n  = 0;
                    if (plan_q.size() == 0) bound_fail("apb_unexpected_transfer");
                    else cur = plan_q.pop_front();
                end
                chk("apb_paddr", 64'(bus.apb_paddr), 64'(cur.addr));
                chk("apb_pwrite", 64'(bus.apb_pwrite), 64'(cur.wr));
                if (cur.wr) chk("apb_pwdata", 64'(bus.apb_pwdata), 64'(cur.wdata));
                acc_n++;
                last_alen = acc_n;
                rdy = (acc_n > cur.w);
                bus.apb_pready  = rdy;
                bus.apb_pslverr = rdy ? cur.err : 1'($urandom);
                if (rdy && !cur.wr)
                    bus.apb_prdata = slave_mem.exists(int'(cur.addr)) ?
                                     slave_mem[int'(cur.addr)] : init_val(cur.addr);
                else
                    bus.apb_prdata = $urandom;
                if (rdy && cur.wr && !cur.err) slave_mem[int'(cur.addr)] = bus.apb_pwdata;
            end else begin
                in_acc = 0;
                bus.apb_pready  = 1'b0;
                bus.apb_pslverr = 1'($urandom);
                bus.apb_prdata  = $urandom;
            end
        end
    end

    // Response monitor: pops the scoreboard on each new response
    initial begin : p_monitor
        exp_t        e;
        logic [31:0] s_rdata;
        logic        s_err;
        logic        s_to;
        holding       = 0;
        bus.rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                holding       = 0;
                bus.rsp_ready = 1'b0;
            end else if (bus.rsp_valid) begin
                if (!holding) begin
                    holding = 1;
                    if (exp_q.size() == 0) begin
                        bound_fail("rsp_unexpected");
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
                        chk("rsp_error", 64'(bus.rsp_error), 64'(e.error));
                        chk("rsp_timeout", 64'(bus.rsp_timeout), 64'(e.timeout));
                        chk("rsp_latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
                        chk("access_len", 64'(last_alen), 64'(e.alen));
                    end
                    s_rdata = bus.rsp_rdata;
                    s_err   = bus.rsp_error;
                    s_to    = bus.rsp_timeout;
                end else begin
                    chk("rsp_stable", 64'({bus.rsp_rdata, bus.rsp_error, bus.rsp_timeout}),
                        64'({s_rdata, s_err, s_to}));
                end
                chk("resp_req_ready", 64'(bus.req_ready), 64'd0);
                chk("resp_psel", 64'({bus.apb_psel, bus.apb_penable}), 64'd0);
                chk("resp_busy", 64'(bus.busy), 64'd1);
                if (bp_left > 0) begin
                    bp_left--;
                    bus.rsp_ready = 1'b0;
                end else begin
                    bus.rsp_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
                if (bus.rsp_ready) holding = 0;
            end else begin
                bus.rsp_ready = 1'b0;
            end
        end
    end

    initial begin : p_watchdog
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    // Directed scenarios, reset abort, then randomized traffic
    initial begin : p_main
        int          guard;
        logic [11:0] a;
        int          r;
        int          w;
        n_chk = 0; n_pass = 0; bp_left = 0; rand_ready = 0; last_alen = 0; cyc = 0;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 12'd0;
        bus.req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", 64'(bus.req_ready), 64'd1);
        chk("reset_outputs", 64'({bus.rsp_valid, bus.busy, bus.apb_psel, bus.apb_penable,
                                  bus.apb_pwrite, bus.rsp_error, bus.rsp_timeout}), 64'd0);
        chk("reset_paddr", 64'(bus.apb_paddr), 64'd0);
        chk("reset_pwdata", 64'(bus.apb_pwdata), 64'd0);
        chk("reset_rdata", 64'(bus.rsp_rdata), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Zero-wait write, wait-stated read, slave error, timeouts
        issue(1'b1, 12'h010, 32'hA5A5_0001, 0, 1'b0);
        issue(1'b1, 12'h020, 32'h0000_0013, 0, 1'b0);
        issue(1'b0, 12'h020, 32'h0, 3, 1'b0);
        issue(1'b0, 12'h020, 32'h0, 0, 1'b1);
        issue(1'b0, 12'h030, 32'h0, STUCK, 1'b0);
        drain();
        chk("psel_after_timeout", 64'({bus.apb_psel, bus.apb_penable}), 64'd0);
        issue(1'b0, 12'h020, 32'h0, T - 1, 1'b0);
        issue(1'b1, 12'h040, 32'hDEAD_BEEF, STUCK, 1'b0);
        issue(1'b0, 12'h040, 32'h0, 1, 1'b0);
        drain();

        // Back-pressure on the first of three back-to-back requests
        bp_left = 5;
        issue(1'b1, 12'h100, 32'h1111_0100, 0, 1'b0);
        issue(1'b1, 12'h104, 32'h2222_0104, 1, 1'b0);
        issue(1'b0, 12'h100, 32'h0, 2, 1'b0);
        drain();

        // Reset in the middle of ACCESS discards the transfer
        plan_q.push_back('{1'b0, 12'h050, 32'h0, STUCK, 1'b0});
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 12'h050;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        guard = 0;
        while (!(bus.apb_psel && bus.apb_penable) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) bound_fail("reach_access");
        repeat (2) @(negedge clk);
        chk("pre_reset_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_async_strobes", 64'({bus.apb_psel, bus.apb_penable, bus.rsp_valid}), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        plan_q.delete();
        issue(1'b0, 12'h010, 32'h0, 2, 1'b0);
        drain();

        // Randomized traffic with random response back-pressure
        rand_ready = 1;
        for (int i = 0; i < 60; i++) begin
            a = 12'($urandom_range(0, 15) * 4);
            r = $urandom_range(0, 9);
            if (r < 5)       w = 0;
            else if (r < 8)  w = $urandom_range(1, 4);
            else if (r == 8) w = T - 1;
            else             w = STUCK;
            issue(1'($urandom), a, $urandom, w, 1'($urandom_range(0, 4) == 0));
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
